// File: rtl/stall_fifo_param.sv
// Parametrised stall FIFO between pipeline stages: DEPTH x WIDTH circular buffer
// with valid/ready on both sides, synchronous flush, almost-full and sticky errors.

module stall_fifo_param_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (we)   q <= d;
  end
endmodule

module stall_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             err_ovf,
  output logic             err_udf,
  input  logic             err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [PW-1:0]                 rd_ptr, wr_ptr;
  logic [CW-1:0]                 cnt_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic                          push, pop;

  assign in_ready    = (cnt_q != FULL_CNT);
  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign almost_full = (cnt_q >= AF_CNT);
  assign count       = cnt_q;

  // Flush masks both handshakes so nothing moves in a squash cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    stall_fifo_param_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush),
      .we      (push && (wr_ptr == PW'(i))),
      .d       (in_data),
      .q       (mem[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= (in_valid & ~in_ready & ~flush) | (err_ovf & ~err_clr);
      err_udf <= (out_ready & ~out_valid & ~flush) | (err_udf & ~err_clr);
    end
  end
endmodule

// File: tb/tb_stall_fifo_param.sv
// Directed bench for stall_fifo_param (DEPTH=4, WIDTH=32, AF_LEVEL=3).

module tb_stall_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             err_ovf;
  logic             err_udf;
  logic             err_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stall_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf),
    .err_clr     (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_errs", {err_ovf, err_udf}, 0);
    reset_n = 1'b1;

    // underflow to get a sticky flag, then 3 pushes, then reset mid-stream
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pre_udf", err_udf, 1);
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i); tick();
    end
    in_valid = 1'b0;
    chk("mid_count3", count, 3);
    reset_n = 1'b0; #1;
    chk("async_count", count, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_errs", {err_ovf, err_udf}, 0);
    tick();
    reset_n = 1'b1;

    // first push latency
    in_valid = 1'b1; in_data = 32'hA0; #1;
    chk("no_comb_pass", out_valid, 0);
    tick(); in_valid = 1'b0;
    chk("a0_valid", out_valid, 1);
    chk("a0_data", out_data, 32'hA0);
    chk("a0_count", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("a0_popped", count, 0);

    // fill to full
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i); tick();
      chk("fill_count", count, 64'(i));
      chk("fill_af", almost_full, (i >= 3) ? 64'd1 : 64'd0);
      chk("fill_in_ready", in_ready, (i < 4) ? 64'd1 : 64'd0);
    end
    in_data = 32'h5; tick(); in_valid = 1'b0;
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", out_data, 64'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_zero", out_data, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_after_ovf", {err_ovf, err_udf}, 0);

    // simultaneous push/pop at count 2
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + WIDTH'(i); tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'h12 + WIDTH'(k);
      chk("pp_data", out_data, 64'h10 + 64'(k));
      tick();
      chk("pp_count", count, 2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", out_data, 32'h1A); tick();
    chk("pp_tail1", out_data, 32'h1B); tick();
    out_ready = 1'b0;
    chk("pp_empty", count, 0);
    chk("pp_noerr", {err_ovf, err_udf}, 0);

    // full with pop: push refused, head popped
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h20 + WIDTH'(i); tick();
    end
    in_data = 32'h24; out_ready = 1'b1; #1;
    chk("fp_in_ready", in_ready, 0);
    tick(); out_ready = 1'b0;
    chk("fp_count3", count, 3);
    chk("fp_head", out_data, 32'h21);
    chk("fp_ovf", err_ovf, 1);
    tick(); in_valid = 1'b0;
    chk("fp_count4", count, 4);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // flush priority at count 3
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("fl_pre", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_errs", {err_ovf, err_udf}, 0);
    in_valid = 1'b1; in_data = 32'h55; tick(); in_valid = 1'b0;
    chk("fl_55", out_data, 32'h55);
    chk("fl_55_count", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // underflow and clear
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("udf_set", err_udf, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("udf_clr", {err_ovf, err_udf}, 0);
    err_clr = 1'b1; out_ready = 1'b1; tick(); err_clr = 1'b0; out_ready = 1'b0;
    chk("udf_set_wins", err_udf, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
